// File: rtl/hamming_encoder_7_4.sv
// ---------------------------------------------------------------------------
// hamming_encoder_7_4
//
// Registered Hamming(7,4) encoder for the UART transmit datapath. It sits
// ahead of the serializer. A nibble sampled while `ena` is high is encoded
// combinationally and then passes through PIPE_STAGES register stages. Each
// stage carries a {valid, code} pair.
//
// Codeword layout (code_out[k] is Hamming position k+1):
//   [0]=p1 [1]=p2 [2]=d1 [3]=p4 [4]=d2 [5]=d3 [6]=d4
//
// Optional build macro:
//   HAMMING_SELFCHECK_EN
//     When defined, a syndrome checker watches the final stage. It raises
//     check_err on the cycle after a valid codeword with a nonzero syndrome.
//     When undefined, check_err is tied low and no checker logic exists.
// ---------------------------------------------------------------------------
module hamming_encoder_7_4 #(
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    output logic [6:0] code_out,
    output logic       valid_out,
    output logic       check_err
);

    // Latency is 1..3 register stages; anything else is rejected at elaboration.
    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_pipe_stages
            $error("hamming_encoder_7_4: PIPE_STAGES must be in 1..3");
        end
    endgenerate

    // Compute the parity bits and place them with the data bits in positions 1..7.
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

`ifdef HAMMING_SELFCHECK_EN
    // Return the syndrome {s4, s2, s1}. A well-formed codeword gives zero.
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
        logic s1;
        logic s2;
        logic s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction
`endif

    // Index 0 is the combinational encoder output. Indices 1..PIPE_STAGES are registers.
    logic [6:0] code_p [0:PIPE_STAGES];
    logic       vld_p  [0:PIPE_STAGES];

    // ---- stage p0: combinational encode of the sampled nibble ----
    assign code_p[0] = hamming_encode(data_in);
    assign vld_p[0]  = ena;

    // ---- stages p1..pN: register chain ----
    // A stage loads its code only when the word feeding it is valid. This does
    // two things: idle cycles keep the last valid codeword on code_out, and an
    // undriven data_in while ena is low never enters the chain.
    generate
        for (genvar s = 1; s <= PIPE_STAGES; s++) begin : g_stage
            // Shift valid every cycle. Capture code only behind a valid word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p[s]  <= 1'b0;
                    code_p[s] <= 7'h00;
                end else begin
                    vld_p[s] <= vld_p[s-1];
                    if (vld_p[s-1]) begin
                        code_p[s] <= code_p[s-1];
                    end
                end
            end
        end
    endgenerate

    // ---- output: final register stage ----
    assign code_out  = code_p[PIPE_STAGES];
    assign valid_out = vld_p[PIPE_STAGES];

`ifdef HAMMING_SELFCHECK_EN
    // Flag an internal fault one cycle after a valid word that fails its own syndrome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_err <= 1'b0;
        end else begin
            check_err <= valid_out & (|hamming_syndrome(code_out));
        end
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_encoder_7_4.sv
// ---------------------------------------------------------------------------
// tb_hamming_encoder_7_4
//
// Directed bench for hamming_encoder_7_4. It drives two instances from the
// same inputs: one with PIPE_STAGES=1 and one with PIPE_STAGES=3. Expected
// codewords come from a hand-computed table.
// ---------------------------------------------------------------------------
module tb_hamming_encoder_7_4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] data_in;

    logic [6:0] code_out_1;
    logic       valid_out_1;
    logic       check_err_1;
    logic [6:0] code_out_3;
    logic       valid_out_3;
    logic       check_err_3;

    int checks = 0;
    int errors = 0;

    // Hand-computed codewords for nibbles 0..F.
    logic [6:0] exp_code [16] = '{
        7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
        7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F
    };

    hamming_encoder_7_4 #(.PIPE_STAGES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .data_in   (data_in),
        .code_out  (code_out_1),
        .valid_out (valid_out_1),
        .check_err (check_err_1)
    );

    hamming_encoder_7_4 #(.PIPE_STAGES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .data_in   (data_in),
        .code_out  (code_out_3),
        .valid_out (valid_out_3),
        .check_err (check_err_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop a run that somehow stalls, so it cannot hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock edge, then wait until the outputs settle.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        ena     = 1'b0;
        data_in = 4'h0;
        for (int i = 0; i < 4; i++) begin
            ena     = i[0];
            data_in = 4'hF;
            step();
            checks++;
            if (code_out_1 !== 7'h00 || valid_out_1 !== 1'b0 || check_err_1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_p1 cyc%0d: code=%h valid=%b err=%b required code=00 valid=0 err=0",
                         i, code_out_1, valid_out_1, check_err_1);
            end
            checks++;
            if (code_out_3 !== 7'h00 || valid_out_3 !== 1'b0 || check_err_3 !== 1'b0) begin
                errors++;
                $display("FAIL reset_p3 cyc%0d: code=%h valid=%b err=%b required code=00 valid=0 err=0",
                         i, code_out_3, valid_out_3, check_err_3);
            end
        end
        rst_n = 1'b1;
        ena   = 1'b0;
        step();
        checks++;
        if (valid_out_1 !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: valid=%b required 0", valid_out_1);
        end
        ena     = 1'b1;
        data_in = 4'h1;
        step();
        ena = 1'b0;
        checks++;
        if (valid_out_1 !== 1'b1 || code_out_1 !== 7'h07) begin
            errors++;
            $display("FAIL first_word: valid=%b code=%h required valid=1 code=07",
                     valid_out_1, code_out_1);
        end
        step();
        checks++;
        if (valid_out_1 !== 1'b0) begin
            errors++;
            $display("FAIL first_word_pulse: valid=%b required 0", valid_out_1);
        end
    endtask

    task automatic test_single;
        logic [3:0] nib [5] = '{4'h0, 4'h1, 4'h8, 4'hB, 4'hF};
        logic [6:0] req [5] = '{7'h00, 7'h07, 7'h4B, 7'h55, 7'h7F};
        for (int i = 0; i < 5; i++) begin
            ena     = 1'b1;
            data_in = nib[i];
            step();
            ena = 1'b0;
            checks++;
            if (valid_out_1 !== 1'b1 || code_out_1 !== req[i]) begin
                errors++;
                $display("FAIL single_%h: valid=%b code=%h required valid=1 code=%h",
                         nib[i], valid_out_1, code_out_1, req[i]);
            end
            step();
            checks++;
            if (valid_out_1 !== 1'b0 || code_out_1 !== req[i]) begin
                errors++;
                $display("FAIL single_%h_pulse: valid=%b code=%h required valid=0 code=%h",
                         nib[i], valid_out_1, code_out_1, req[i]);
            end
        end
        // Let the three-stage instance drain before the next scenario.
        step();
        step();
    endtask

    task automatic test_back_to_back;
        logic [2:0] syn;
        logic [3:0] dec;
        for (int k = 0; k < 18; k++) begin
            ena     = (k < 16);
            data_in = k[3:0];
            step();
            if (k < 16) begin
                syn[0] = code_out_1[0] ^ code_out_1[2] ^ code_out_1[4] ^ code_out_1[6];
                syn[1] = code_out_1[1] ^ code_out_1[2] ^ code_out_1[5] ^ code_out_1[6];
                syn[2] = code_out_1[3] ^ code_out_1[4] ^ code_out_1[5] ^ code_out_1[6];
                dec    = {code_out_1[6], code_out_1[5], code_out_1[4], code_out_1[2]};
                checks++;
                if (valid_out_1 !== 1'b1 || code_out_1 !== exp_code[k] || syn !== 3'b000 ||
                    dec !== k[3:0]) begin
                    errors++;
                    $display("FAIL stream_p1_%0d: valid=%b code=%h syn=%b data=%h required valid=1 code=%h syn=000 data=%h",
                             k, valid_out_1, code_out_1, syn, dec, exp_code[k], k[3:0]);
                end
            end else begin
                checks++;
                if (valid_out_1 !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_p1_tail%0d: valid=%b required 0", k, valid_out_1);
                end
            end
            if (k >= 2) begin
                checks++;
                if (valid_out_3 !== 1'b1 || code_out_3 !== exp_code[k-2]) begin
                    errors++;
                    $display("FAIL stream_p3_%0d: valid=%b code=%h required valid=1 code=%h",
                             k, valid_out_3, code_out_3, exp_code[k-2]);
                end
            end else begin
                checks++;
                if (valid_out_3 !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_p3_lead%0d: valid=%b required 0", k, valid_out_3);
                end
            end
            checks++;
            if (check_err_1 !== 1'b0 || check_err_3 !== 1'b0) begin
                errors++;
                $display("FAIL stream_check_err_%0d: err1=%b err3=%b required 0 0",
                         k, check_err_1, check_err_3);
            end
        end
    endtask

    task automatic test_hold;
        logic [3:0] junk [5] = '{4'h3, 4'hC, 4'bxxxx, 4'h0, 4'hF};
        ena     = 1'b1;
        data_in = 4'hB;
        step();
        checks++;
        if (valid_out_1 !== 1'b1 || code_out_1 !== 7'h55) begin
            errors++;
            $display("FAIL hold_load: valid=%b code=%h required valid=1 code=55",
                     valid_out_1, code_out_1);
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = junk[i];
            step();
            checks++;
            if (valid_out_1 !== 1'b0 || code_out_1 !== 7'h55) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b code=%h required valid=0 code=55",
                         i, valid_out_1, code_out_1);
            end
        end
        checks++;
        if (valid_out_3 !== 1'b0 || code_out_3 !== 7'h55) begin
            errors++;
            $display("FAIL hold_p3: valid=%b code=%h required valid=0 code=55",
                     valid_out_3, code_out_3);
        end
        data_in = 4'h0;
    endtask

    task automatic test_reset_inflight;
        ena     = 1'b1;
        data_in = 4'h1;
        step();
        data_in = 4'h2;
        step();
        ena = 1'b0;
        // Two words are now inside the three-stage chain. Reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out_3 !== 1'b0 || code_out_3 !== 7'h00) begin
            errors++;
            $display("FAIL inflight_async_clear: valid=%b code=%h required valid=0 code=00",
                     valid_out_3, code_out_3);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valid_out_3 !== 1'b0 || code_out_3 !== 7'h00) begin
                errors++;
                $display("FAIL inflight_stale_%0d: valid=%b code=%h required valid=0 code=00",
                         i, valid_out_3, code_out_3);
            end
        end
        ena     = 1'b1;
        data_in = 4'hC;
        for (int i = 0; i < 4; i++) begin
            step();
            ena = 1'b0;
            checks++;
            if (valid_out_3 !== (i == 2)) begin
                errors++;
                $display("FAIL inflight_relat_%0d: valid=%b required %b",
                         i, valid_out_3, (i == 2));
            end
        end
        checks++;
        if (code_out_3 !== 7'h61) begin
            errors++;
            $display("FAIL inflight_code: code=%h required 61", code_out_3);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
